wb_regfile: RTL

- Write-back sink for the MEM/WB pipeline register.
- Consumes the registered WB-stage write bundle and owns the 32x32 general register file and the HI/LO pair.
- Provides two ID-stage read ports and one HI/LO read port, each with same-cycle write-through bypass.
- Drives the debug trace port that the func-test harness compares at commit.
- Sits between the MEM/WB register and the ID stage; CP0 write fields are consumed by cp0 and are not ports here.

---
 rtl/wb_regfile_pkg.sv | 11 +
 rtl/wb_regfile_hilo_reg.sv | 35 +++
 rtl/wb_regfile.sv | 90 +++++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back register file: widths, the hardwired zero
// index and the trace byte-enable pattern.
package wb_regfile_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;

   localparam logic [RF_ADDR_W-1:0] GPR_ZERO = 5'd0;
   localparam logic [3:0]           WEN_ALL  = 4'hf;

endpackage

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO register pair with independent write enables and same-cycle bypass,
// so a mult/div result committing in WB is visible to the ID stage at once.
module hilo_reg
   import wb_regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              hi_write_enable,
   input  logic [DATA_W-1:0] hi_write_data,
   input  logic              lo_write_enable,
   input  logic [DATA_W-1:0] lo_write_data,
   output logic [DATA_W-1:0] hi_data,
   output logic [DATA_W-1:0] lo_data
);

   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (hi_write_enable) hi_q <= hi_write_data;
         if (lo_write_enable) lo_q <= lo_write_data;
      end
   end

   // The bypass ignores reset on purpose: a pending write is still visible in the reset cycle.
   assign hi_data = hi_write_enable ? hi_write_data : hi_q;
   assign lo_data = lo_write_enable ? lo_write_data : lo_q;

endmodule

// File: rtl/wb_regfile.sv
// Write-back sink: owns the 32x32 GPR file and HI/LO, serves two bypassed ID read
// ports and drives the commit trace port.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              wb_regfile_write_enable_i,
   input  logic [ADDR_W-1:0] wb_regfile_write_addr_i,
   input  logic [DATA_W-1:0] wb_regfile_write_data_i,
   input  logic              wb_hi_write_enable_i,
   input  logic [DATA_W-1:0] wb_hi_write_data_i,
   input  logic              wb_lo_write_enable_i,
   input  logic [DATA_W-1:0] wb_lo_write_data_i,
   input  logic [31:0]       wb_pc_i,
   input  logic [ADDR_W-1:0] id_read_addr1_i,
   input  logic [ADDR_W-1:0] id_read_addr2_i,
   output logic [DATA_W-1:0] id_read_data1_o,
   output logic [DATA_W-1:0] id_read_data2_o,
   output logic [DATA_W-1:0] hi_data_o,
   output logic [DATA_W-1:0] lo_data_o,
   output logic [31:0]       debug_wb_pc,
   output logic [3:0]        debug_wb_rf_wen,
   output logic [ADDR_W-1:0] debug_wb_rf_wnum,
   output logic [DATA_W-1:0] debug_wb_rf_wdata
);

   localparam int                 NUM_REGS  = 2**ADDR_W;
   localparam logic [ADDR_W-1:0]  ZERO_IDX  = ADDR_W'(GPR_ZERO);

   logic [DATA_W-1:0] gpr [NUM_REGS];
   logic              gpr_write;

   assign gpr_write = wb_regfile_write_enable_i && (wb_regfile_write_addr_i != ZERO_IDX);

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
      end else if (gpr_write) begin
         gpr[wb_regfile_write_addr_i] <= wb_regfile_write_data_i;
      end
   end

   // Index 0 wins over the bypass so a write aimed at $zero can never leak out.
   always_comb begin
      id_read_data1_o = gpr[id_read_addr1_i];
      if (id_read_addr1_i == ZERO_IDX)
         id_read_data1_o = '0;
      else if (wb_regfile_write_enable_i && wb_regfile_write_addr_i == id_read_addr1_i)
         id_read_data1_o = wb_regfile_write_data_i;
   end

   always_comb begin
      id_read_data2_o = gpr[id_read_addr2_i];
      if (id_read_addr2_i == ZERO_IDX)
         id_read_data2_o = '0;
      else if (wb_regfile_write_enable_i && wb_regfile_write_addr_i == id_read_addr2_i)
         id_read_data2_o = wb_regfile_write_data_i;
   end

   hilo_reg #(
      .DATA_W (DATA_W)
   ) u_hilo_reg (
      .clock_i         (clock_i),
      .reset_i         (reset_i),
      .hi_write_enable (wb_hi_write_enable_i),
      .hi_write_data   (wb_hi_write_data_i),
      .lo_write_enable (wb_lo_write_enable_i),
      .lo_write_data   (wb_lo_write_data_i),
      .hi_data         (hi_data_o),
      .lo_data         (lo_data_o)
   );

   always_comb begin
      debug_wb_pc       = '0;
      debug_wb_rf_wen   = '0;
      debug_wb_rf_wnum  = '0;
      debug_wb_rf_wdata = '0;
      if (!reset_i) begin
         debug_wb_pc       = wb_pc_i;
         debug_wb_rf_wen   = gpr_write ? WEN_ALL : 4'h0;
         debug_wb_rf_wnum  = wb_regfile_write_addr_i;
         debug_wb_rf_wdata = wb_regfile_write_data_i;
      end
   end

endmodule
